// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared opcode, FSM state and command definitions for alu_arbiter
//
// Contents:
//   OP_ADD/OP_SUB/OP_MUL/OP_NEG : 2-bit ALU opcodes
//   ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP : FSM state encoding
//   alu_cmd_t : latched operation (opcode + two operand bytes)
//   pick_op/pick_byte : extract one requester's slice from a packed request bus
package alu_arbiter_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_NEG = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  function automatic logic [1:0] pick_op(input logic [3:0] bus, input logic sel);
    return sel ? bus[3:2] : bus[1:0];
  endfunction

  function automatic logic [7:0] pick_byte(input logic [15:0] bus, input logic sel);
    return sel ? bus[15:8] : bus[7:0];
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// rtl/alu_arbiter_rr.sv - two-requester round-robin arbiter (module rr_arbiter2)
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   req[1:0] : request vector, bit i = requester i
//   en       : arbitration enable; grant is forced to 0 when low
//   grant[1:0] : one-hot grant (combinational)
// The tie-break pointer flips to the other requester whenever a grant is issued,
// and after reset requester 0 wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // 1: requester 1 wins a tie; 0: requester 0 wins a tie
  logic prio1;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant = prio1 ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

  // Whoever was just granted loses the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 prio1 <= 1'b0;
    else if (grant != 2'b00) prio1 <= grant[0];
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two requesters (IDLE/ISSUE/WAIT/RESP)
//
// Parameters:
//   TIMEOUT_CYCLES : WAIT cycles without alu_ready before abort (only with ALU_ARB_TIMEOUT_EN)
// Optional feature macro: ALU_ARB_TIMEOUT_EN (WAIT timeout with resp_err; default build has none)
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid[1:0]           : per-requester request
//   req_op[3:0]              : per-requester opcode, [2i+1:2i]
//   req_a[15:0], req_b[15:0] : per-requester operands, [8i+7:8i]
//   req_accept[1:0]          : one-hot accept pulse (in IDLE)
//   resp_valid[1:0]          : one-hot response strobe (in RESP)
//   resp_hi, resp_lo         : captured result bytes, held until next RESP
//   resp_err                 : timeout abort flag, held with the result
//   alu_en, alu_state        : ALU enable and opcode
//   alu_value1, alu_value2   : ALU operands
//   alu_out1, alu_out2       : ALU result bytes
//   alu_ready                : ALU done
import alu_arbiter_pkg::*;

module alu_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [1:0]  req_accept,
  output logic [1:0]  resp_valid,
  output logic [7:0]  resp_hi,
  output logic [7:0]  resp_lo,
  output logic        resp_err,
  output logic        alu_en,
  output logic [1:0]  alu_state,
  output logic [7:0]  alu_value1,
  output logic [7:0]  alu_value2,
  input  logic [7:0]  alu_out1,
  input  logic [7:0]  alu_out2,
  input  logic        alu_ready
);

  logic [1:0] state;
  logic       gnt_idx;
  alu_cmd_t   cmd;
  logic [7:0] hi_q;
  logic [7:0] lo_q;
  logic       err_q;
  logic [1:0] grant;
  logic       arb_en;
  logic       timeout;

  // rst gates the enable so no accept can leak out while reset is held.
  assign arb_en = (state == ST_IDLE) && !rst;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (arb_en),
    .grant (grant)
  );

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // wait_cnt counts completed WAIT cycles; abort on the last allowed one.
  assign timeout = (state == ST_WAIT) && !alu_ready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wait_cnt <= '0;
    else if (state != ST_WAIT)  wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + CW'(1);
  end
`else
  // No abort path in this build; the expression is constant 0 for any legal parameter.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gnt_idx <= 1'b0;
      cmd     <= '0;
      hi_q    <= 8'h00;
      lo_q    <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            gnt_idx <= grant[1];
            cmd.op  <= pick_op(req_op, grant[1]);
            cmd.a   <= pick_byte(req_a, grant[1]);
            cmd.b   <= pick_byte(req_b, grant[1]);
            state   <= ST_ISSUE;
          end
        end
        // alu_ready here may belong to a previous operation, so it is not looked at.
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (alu_ready) begin
            hi_q  <= alu_out1;
            lo_q  <= (cmd.op == OP_MUL) ? alu_out2 : 8'h00;
            err_q <= 1'b0;
            state <= ST_RESP;
          end else if (timeout) begin
            hi_q  <= 8'h00;
            lo_q  <= 8'h00;
            err_q <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_accept = grant;
  assign resp_valid = (state == ST_RESP) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign resp_hi    = hi_q;
  assign resp_lo    = lo_q;
  assign resp_err   = err_q;
  assign alu_en     = (state == ST_ISSUE) || (state == ST_WAIT);
  assign alu_state  = cmd.op;
  assign alu_value1 = cmd.a;
  assign alu_value2 = cmd.b;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
import alu_arbiter_pkg::*;

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  req_accept;
  logic [1:0]  resp_valid;
  logic [7:0]  resp_hi;
  logic [7:0]  resp_lo;
  logic        resp_err;
  logic        alu_en;
  logic [1:0]  alu_state;
  logic [7:0]  alu_value1;
  logic [7:0]  alu_value2;
  logic [7:0]  alu_out1 = 8'h00;
  logic [7:0]  alu_out2 = 8'h00;
  logic        alu_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int alu_lat = 2;   // ALU done after this many enabled cycles; 0 = never
  int en_cnt = 0;

  alu_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_accept (req_accept),
    .resp_valid (resp_valid),
    .resp_hi    (resp_hi),
    .resp_lo    (resp_lo),
    .resp_err   (resp_err),
    .alu_en     (alu_en),
    .alu_state  (alu_state),
    .alu_value1 (alu_value1),
    .alu_value2 (alu_value2),
    .alu_out1   (alu_out1),
    .alu_out2   (alu_out2),
    .alu_ready  (alu_ready)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; alu_out2 carries junk for non-MUL ops so lo forcing is visible.
  logic [15:0] prod;
  always @(negedge clk) begin
    if (alu_en) en_cnt = en_cnt + 1;
    else        en_cnt = 0;
    alu_ready = alu_en && (alu_lat != 0) && (en_cnt >= alu_lat);
    prod = 16'(alu_value1) * 16'(alu_value2);
    case (alu_state)
      OP_ADD:  begin alu_out1 = alu_value1 + alu_value2; alu_out2 = 8'hA5; end
      OP_SUB:  begin alu_out1 = alu_value1 - alu_value2; alu_out2 = 8'hA5; end
      OP_MUL:  begin alu_out1 = prod[15:8];              alu_out2 = prod[7:0]; end
      OP_NEG:  begin alu_out1 = 8'd0 - alu_value1;        alu_out2 = 8'hA5; end
      default: begin alu_out1 = 8'h00;                    alu_out2 = 8'h00; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for an accept, optionally drops and scrambles the granted request,
  // then waits for resp_valid. Ends at the RESP sample point.
  task automatic serve(input string tag, input bit drop, output int idx, output int lat);
    int n;
    int extra;
    n = 0;
    #1;
    while (req_accept == 2'b00 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, " accept seen"}, 32'(req_accept != 2'b00), 1);
    idx = req_accept[1] ? 1 : 0;
    @(posedge clk); #1;
    if (drop) begin
      req_valid[idx]      = 1'b0;
      req_a[idx*8 +: 8]   = ~req_a[idx*8 +: 8];
      req_b[idx*8 +: 8]   = ~req_b[idx*8 +: 8];
      req_op[idx*2 +: 2]  = ~req_op[idx*2 +: 2];
    end
    lat = 0;
    extra = 0;
    do begin
      @(negedge clk); #1; lat++;
      if (resp_valid == 2'b00 && req_accept != 2'b00) extra++;
    end while (resp_valid == 2'b00 && lat < 40);
    check({tag, " no accept in flight"}, extra, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx;
    int lat;
    int n;
    int seen;

    // Reset: requests held high must not produce accepts.
    rst = 1'b1; req_valid = 2'b11; req_op = 4'h0; req_a = 16'h0; req_b = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst accept", req_accept, 2'b00);
    check("rst resp_valid", resp_valid, 2'b00);
    check("rst alu_en", alu_en, 0);
    check("rst resp_hi", resp_hi, 0);
    check("rst resp_lo", resp_lo, 0);
    check("rst resp_err", resp_err, 0);
    check("rst alu_value1", alu_value1, 0);
    @(negedge clk); req_valid = 2'b00; rst = 1'b0;
    @(negedge clk);

    // Requester 0 ADD 5,3, ALU ready 2 cycles after enable.
    alu_lat = 2;
    req_op = 4'b0000; req_a = 16'h0005; req_b = 16'h0003; req_valid = 2'b01;
    serve("add", 1, idx, lat);
    check("add grant", idx, 0);
    check("add latency", lat, 3);
    check("add resp_valid", resp_valid, 2'b01);
    check("add resp_hi", resp_hi, 8'h08);
    check("add resp_lo", resp_lo, 8'h00);
    check("add resp_err", resp_err, 0);
    check("add alu_en in RESP", alu_en, 0);
    @(negedge clk); #1;
    check("add strobe ends", resp_valid, 2'b00);
    check("add hi held", resp_hi, 8'h08);

    // Stale ready during ISSUE must not shorten the operation.
    alu_lat = 1;
    req_op = 4'b0000; req_a = 16'h0007; req_b = 16'h0009; req_valid = 2'b01;
    serve("stale", 1, idx, lat);
    check("stale latency", lat, 3);
    check("stale resp_hi", resp_hi, 8'h10);
    alu_lat = 2;

    // Reset restores requester 0 priority.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Both valid: req0 SUB 10,4, req1 NEG 1.
    req_op = {OP_NEG, OP_SUB}; req_a = {8'd1, 8'd10}; req_b = {8'd0, 8'd4}; req_valid = 2'b11;
    serve("sub", 1, idx, lat);
    check("sub grant", idx, 0);
    check("sub resp_valid", resp_valid, 2'b01);
    check("sub resp_hi", resp_hi, 8'h06);
    serve("neg", 1, idx, lat);
    check("neg grant", idx, 1);
    check("neg resp_valid", resp_valid, 2'b10);
    check("neg resp_hi", resp_hi, 8'hFF);
    check("neg resp_lo", resp_lo, 8'h00);
    req_valid = 2'b00;

    // Both held continuously: grants alternate 0,1,0,1.
    req_op = {OP_ADD, OP_ADD}; req_a = {8'd2, 8'd1}; req_b = {8'd2, 8'd1}; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      serve("rr", 0, idx, lat);
      check($sformatf("rr grant %0d", k), idx, k % 2);
      check($sformatf("rr resp_hi %0d", k), resp_hi, (k % 2 == 0) ? 8'd2 : 8'd4);
    end
    req_valid = 2'b00;

    // Requester 1 MUL 12,11.
    @(negedge clk);
    req_op = {OP_MUL, OP_ADD}; req_a = {8'd12, 8'd0}; req_b = {8'd11, 8'd0}; req_valid = 2'b10;
    serve("mul", 1, idx, lat);
    check("mul resp_valid", resp_valid, 2'b10);
    check("mul resp_hi", resp_hi, 8'h00);
    check("mul resp_lo", resp_lo, 8'h84);

    // Reset during WAIT drops the operation and restores requester 0 priority.
    @(negedge clk);
    alu_lat = 0;
    req_op = 4'b0000; req_a = 16'h0001; req_b = 16'h0001; req_valid = 2'b01;
    n = 0; #1;
    while (req_accept == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    check("rstwait accept", req_accept, 2'b01);
    @(posedge clk); #1; req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    check("rstwait in WAIT", alu_en, 1);
    #2 rst = 1'b1;
    #1;
    check("rstwait alu_en", alu_en, 0);
    check("rstwait resp_valid", resp_valid, 2'b00);
    check("rstwait alu_value1", alu_value1, 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); #1; if (resp_valid != 2'b00) seen++; end
    check("rstwait no response", seen, 0);
    alu_lat = 2;
    req_op = {OP_ADD, OP_ADD}; req_a = {8'd5, 8'd1}; req_b = {8'd5, 8'd1}; req_valid = 2'b11;
    serve("postrst", 1, idx, lat);
    check("postrst grant", idx, 0);
    check("postrst resp_hi", resp_hi, 8'd2);
    req_valid = 2'b00;
    @(negedge clk);

    // ALU never ready.
    alu_lat = 0;
    req_op = 4'b0000; req_a = 16'h0003; req_b = 16'h0003; req_valid = 2'b01;
`ifdef ALU_ARB_TIMEOUT_EN
    serve("timeout", 1, idx, lat);
    check("timeout latency", lat, 6);
    check("timeout resp_valid", resp_valid, 2'b01);
    check("timeout resp_err", resp_err, 1);
    check("timeout resp_hi", resp_hi, 8'h00);
    check("timeout resp_lo", resp_lo, 8'h00);
`else
    n = 0; #1;
    while (req_accept == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    check("nowait accept", req_accept, 2'b01);
    @(posedge clk); #1; req_valid = 2'b00;
    seen = 0;
    repeat (20) begin @(negedge clk); #1; if (resp_valid != 2'b00) seen++; end
    check("nowait no response", seen, 0);
    check("nowait still WAIT", alu_en, 1);
    check("nowait resp_err", resp_err, 0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
